// File: rtl/usb_tx_line_encoder.sv
// -----------------------------------------------------------------------------
// usb_tx_line_encoder
//
// Transmit line encoder for the USB full-speed PHY path. Packet bytes arrive
// from the TX packet controller and are sent LSB first. The encoder inserts
// stuff bits, applies NRZI coding and ends each packet with EOP
// (two bit times of SE0, then one bit time of J). Between packets the line
// is held at idle J.
//
// Optional build macro:
//   USB_TX_SYNC_GEN_EN - when defined, the encoder sends the SYNC pattern
//                        (0x80, LSB first: KJKJKJKK) before the first byte.
//                        SYNC is not stuffed and does not count toward ones.
//                        When undefined, the controller sends 0x80 itself as
//                        an ordinary data byte.
//
// Ports:
//   clk       system clock
//   n_rst     asynchronous active-low reset (line returns to J, no EOP)
//   tx_data   packet byte, sent LSB first
//   tx_valid  tx_data/tx_last are valid
//   tx_last   byte is the final byte of the packet (qualified by tx_valid)
//   tx_ready  encoder can take a byte this cycle (holding buffer empty)
//   d_plus    registered D+ line level
//   d_minus   registered D- line level
//   tx_busy   high from the first accepted byte until EOP completes
//   tx_done   one-cycle pulse in the first idle cycle after EOP
//   tx_error  one-cycle pulse when the buffer underruns mid-packet
//
// Handshake: a byte moves on a rising clk edge where tx_valid && tx_ready.
// tx_ready depends only on the holding buffer, never on tx_valid. tx_valid
// without tx_ready has no effect. tx_last is stored with its byte.
//
// The FSM state is held in the signal 'state', of enum type state_t, so that
// checkers can bind to it.
// -----------------------------------------------------------------------------
`default_nettype none

module usb_tx_line_encoder #(
    parameter int CLKS_PER_BIT = 8,
    parameter int STUFF_LIMIT  = 6
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       d_plus,
    output logic       d_minus,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int OW = $clog2(STUFF_LIMIT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [OW-1:0] ONES_LIMIT = OW'(STUFF_LIMIT);

    // Line levels as {d_plus, d_minus}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
`ifdef USB_TX_SYNC_GEN_EN
        S_SYNC    = 3'd1,
`endif
        S_DATA    = 3'd2,
        S_STUFF   = 3'd3,
        S_EOP_SE0 = 3'd4,
        S_EOP_J   = 3'd5
    } state_t;

    state_t          state, state_n;
    logic [TW-1:0]   timer, timer_n;
    logic [7:0]      sr, sr_n;
    logic [2:0]      bit_cnt, bit_cnt_n;
    logic            cur_last, cur_last_n;
    logic [OW-1:0]   ones, ones_n, ones_inc;
    logic [7:0]      buf_data, buf_data_n;
    logic            buf_last, buf_last_n;
    logic            buf_full, buf_full_n;
    logic [1:0]      line_cur, line_n;
    logic            busy_n, done_n, error_n;
    logic            boundary, next_byte, load;

    // NRZI: a 1 holds the line, a 0 toggles J<->K. The line is never SE0 when
    // this is called, so inverting both wires swaps J and K.
    function automatic logic [1:0] nrzi(input logic bit_val, input logic [1:0] lvl);
        return bit_val ? lvl : ~lvl;
    endfunction

    assign line_cur = {d_plus, d_minus};
    assign tx_ready = !buf_full;
    assign boundary = (timer == TIMER_LAST);

    always_comb begin
        state_n    = state;
        timer_n    = (state == S_IDLE || boundary) ? '0 : timer + TW'(1);
        sr_n       = sr;
        bit_cnt_n  = bit_cnt;
        cur_last_n = cur_last;
        ones_n     = ones;
        ones_inc   = sr[0] ? ones + OW'(1) : '0;
        buf_data_n = buf_data;
        buf_last_n = buf_last;
        buf_full_n = buf_full;
        line_n     = line_cur;
        done_n     = 1'b0;
        error_n    = 1'b0;
        next_byte  = 1'b0;
        load       = 1'b0;

        case (state)
            S_IDLE: begin
                line_n = LINE_J;
                if (buf_full) begin
                    ones_n = '0;
`ifdef USB_TX_SYNC_GEN_EN
                    // First SYNC bit is 0: toggle from J to K
                    state_n    = S_SYNC;
                    bit_cnt_n  = '0;
                    cur_last_n = 1'b0;
                    line_n     = LINE_K;
`else
                    load = 1'b1;
`endif
                end
            end
`ifdef USB_TX_SYNC_GEN_EN
            S_SYNC: begin
                if (boundary) begin
                    // cur_last is clear here, so the byte-end logic below
                    // loads the waiting first packet byte with no gap.
                    if (bit_cnt == 3'd7) begin
                        next_byte = 1'b1;
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                        // SYNC bit index bit_cnt+1 is 1 only for index 7
                        line_n = nrzi(bit_cnt == 3'd6, line_cur);
                    end
                end
            end
`endif
            S_DATA: begin
                if (boundary) begin
                    ones_n    = ones_inc;
                    sr_n      = {1'b0, sr[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (ones_inc == ONES_LIMIT) begin
                        state_n = S_STUFF;
                        ones_n  = '0;
                        line_n  = ~line_cur;
                    end else if (bit_cnt == 3'd7) begin
                        next_byte = 1'b1;
                    end else begin
                        line_n = nrzi(sr[1], line_cur);
                    end
                end
            end
            S_STUFF: begin
                if (boundary) begin
                    // A stuff bit always follows a data bit, so bit_cnt is
                    // only zero here once bit 7 has been sent.
                    if (bit_cnt == 3'd0) begin
                        next_byte = 1'b1;
                    end else begin
                        state_n = S_DATA;
                        line_n  = nrzi(sr[0], line_cur);
                    end
                end
            end
            S_EOP_SE0: begin
                if (boundary) begin
                    if (bit_cnt[0]) begin
                        state_n = S_EOP_J;
                        line_n  = LINE_J;
                    end else begin
                        bit_cnt_n = 3'd1;
                    end
                end
            end
            S_EOP_J: begin
                if (boundary) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                line_n  = LINE_J;
            end
        endcase

        // End of a byte: continue with the buffered byte, or close the packet
        if (next_byte) begin
            if (!cur_last && buf_full) begin
                load = 1'b1;
            end else begin
                error_n   = !cur_last;
                state_n   = S_EOP_SE0;
                line_n    = LINE_SE0;
                bit_cnt_n = '0;
            end
        end

        // Drain the holding buffer into the shift register and register the
        // first bit's level. The ones count carries across bytes.
        if (load) begin
            state_n    = S_DATA;
            sr_n       = buf_data;
            bit_cnt_n  = '0;
            cur_last_n = buf_last;
            buf_full_n = 1'b0;
            line_n     = nrzi(buf_data[0], line_cur);
        end

        if (tx_valid && !buf_full) begin
            buf_data_n = tx_data;
            buf_last_n = tx_last;
            buf_full_n = 1'b1;
        end

        busy_n = (state_n != S_IDLE) || buf_full_n;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= S_IDLE;
            timer    <= '0;
            sr       <= '0;
            bit_cnt  <= '0;
            cur_last <= 1'b0;
            ones     <= '0;
            buf_data <= '0;
            buf_last <= 1'b0;
            buf_full <= 1'b0;
            d_plus   <= 1'b1;
            d_minus  <= 1'b0;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            sr       <= sr_n;
            bit_cnt  <= bit_cnt_n;
            cur_last <= cur_last_n;
            ones     <= ones_n;
            buf_data <= buf_data_n;
            buf_last <= buf_last_n;
            buf_full <= buf_full_n;
            d_plus   <= line_n[1];
            d_minus  <= line_n[0];
            tx_busy  <= busy_n;
            tx_done  <= done_n;
            tx_error <= error_n;
        end
    end

endmodule

`default_nettype wire
